// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED sequencer.
// Holds state encoding, mode codes, start patterns and period lengths.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_NONE  = 2'd0;
    localparam logic [1:0] MODE_ROT   = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PP    = 2'd3;

    localparam logic [3:0] PAT_ROT   = 4'b0001;
    localparam logic [3:0] PAT_BLINK = 4'b1111;
    localparam logic [3:0] PAT_PP    = 4'b0001;

    localparam logic [2:0] PER_ROT   = 3'd4;
    localparam logic [2:0] PER_BLINK = 3'd2;
    localparam logic [2:0] PER_PP    = 3'd6;

    function automatic logic [3:0] init_pat(input logic [1:0] m);
        case (m)
            MODE_BLINK: return PAT_BLINK;
            MODE_PP:    return PAT_PP;
            default:    return PAT_ROT;
        endcase
    endfunction

    function automatic logic [2:0] period(input logic [1:0] m);
        case (m)
            MODE_BLINK: return PER_BLINK;
            MODE_PP:    return PER_PP;
            default:    return PER_ROT;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: step-rate prescaler for the LED sequencer.
// tick is the combinational terminal-count flag while enabled.
module led_tick_gen #(
    parameter int TICK_CYCLES = 12_500_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_CYCLES + 1);
    localparam logic [CW-1:0] TC_LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TC_LAST);

    // Count enabled cycles, wrapping at the terminal count.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: plays rotate / blink / ping-pong on the 4-bit LED bank.
// Runs a latched number of periods (0 = forever); stop aborts at once.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_CYCLES = 12_500_000,
    parameter int REP_W       = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [REP_W-1:0] rep_count,
    output logic [3:0]       led,
    output logic             busy,
    output logic             step_tick,
    output logic             cycle_done,
    output logic             done
);

    state_t           state;
    logic [1:0]       mode_q;
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] cycle_cnt;
    logic [2:0]       step_cnt;
    logic             dir_left;
    logic             tick;
    logic [3:0]       led_nxt;
    logic             dir_nxt;
    logic             period_end;
    logic             rep_hit;

    led_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .sys_clk(sys_clk),
        .rst    (rst),
        .clr    (state != RUN),
        .en     (state == RUN),
        .tick   (tick)
    );

    assign period_end = (step_cnt == period(mode_q) - 3'd1);
    assign rep_hit    = (rep_q != '0) && (cycle_cnt + 1'b1 == rep_q);

    // Next LED pattern and ping-pong direction for one step.
    always_comb begin
        led_nxt = led;
        dir_nxt = dir_left;
        case (mode_q)
            MODE_BLINK: led_nxt = ~led;
            MODE_PP: begin
                led_nxt = dir_left ? (led << 1) : (led >> 1);
                if (led_nxt == 4'b1000)
                    dir_nxt = 1'b0;
                else if (led_nxt == 4'b0001)
                    dir_nxt = 1'b1;
            end
            default: led_nxt = {led[2:0], led[3]};
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= MODE_NONE;
            rep_q      <= '0;
            cycle_cnt  <= '0;
            step_cnt   <= '0;
            dir_left   <= 1'b1;
            led        <= 4'b0000;
            busy       <= 1'b0;
            step_tick  <= 1'b0;
            cycle_done <= 1'b0;
            done       <= 1'b0;
        end else begin
            step_tick  <= 1'b0;
            cycle_done <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    led  <= 4'b0000;
                    busy <= 1'b0;
                    if (start && !stop && mode != MODE_NONE) begin
                        mode_q <= mode;
                        rep_q  <= rep_count;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        led   <= 4'b0000;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        led       <= init_pat(mode_q);
                        step_cnt  <= '0;
                        cycle_cnt <= '0;
                        dir_left  <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        led   <= 4'b0000;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tick) begin
                        step_tick <= 1'b1;
                        if (period_end) begin
                            cycle_done <= 1'b1;
                            step_cnt   <= '0;
                            if (cycle_cnt != '1)
                                cycle_cnt <= cycle_cnt + 1'b1;
                        end else begin
                            step_cnt <= step_cnt + 3'd1;
                        end
                        if (period_end && rep_hit) begin
                            led   <= 4'b0000;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            led      <= led_nxt;
                            dir_left <= dir_nxt;
                        end
                    end
                end
                DONE: begin
                    led   <= 4'b0000;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: random stimulus on two sequencers (step rate 4 and 1)
// against a timeline model of the expected LED output.
module tb_led_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [3:0] rep_count;

    logic [3:0] led4, led1;
    logic       busy4, busy1;
    logic       st4, st1;
    logic       cd4, cd1;
    logic       dn4, dn1;
    logic [7:0] o4, o1;

    int n_tests = 0;
    int n_fail  = 0;

    bit act [2];
    int nn  [2];
    int mm  [2];
    int rr  [2];
    int tk  [2];

    assign o4 = {led4, busy4, st4, cd4, dn4};
    assign o1 = {led1, busy1, st1, cd1, dn1};

    led_seq_ctrl #(
        .TICK_CYCLES(4),
        .REP_W      (4)
    ) u_dut4 (
        .sys_clk   (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .rep_count (rep_count),
        .led       (led4),
        .busy      (busy4),
        .step_tick (st4),
        .cycle_done(cd4),
        .done      (dn4)
    );

    led_seq_ctrl #(
        .TICK_CYCLES(1),
        .REP_W      (4)
    ) u_dut1 (
        .sys_clk   (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .rep_count (rep_count),
        .led       (led1),
        .busy      (busy1),
        .step_tick (st1),
        .cycle_done(cd1),
        .done      (dn1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b want=%b", tag, $time, got, exp);
        end
    endtask

    function automatic int per(input int m);
        if (m == 1) return 4;
        if (m == 2) return 2;
        return 6;
    endfunction

    function automatic logic [3:0] pat(input int m, input int k);
        logic [3:0] one;
        one = 4'b0001;
        if (m == 1) return one << k;
        if (m == 2) return (k == 0) ? 4'hF : 4'h0;
        return (k <= 3) ? (one << k) : (one << (6 - k));
    endfunction

    function automatic int end_n(input int i);
        return 1 + rr[i] * per(mm[i]) * tk[i];
    endfunction

    // Expected {led, busy, step_tick, cycle_done, done} from elapsed time.
    function automatic logic [7:0] mexp(input int i);
        int p, s;
        logic st, cd;
        if (!act[i]) return 8'h00;
        if (nn[i] == 0) return 8'b0000_1000;
        p = per(mm[i]);
        if (rr[i] != 0 && nn[i] == end_n(i)) return 8'b0000_0111;
        s  = (nn[i] - 1) / tk[i];
        st = (s > 0) && ((nn[i] - 1) % tk[i] == 0);
        cd = st && (s % p == 0);
        return {pat(mm[i], s % p), 1'b1, st, cd, 1'b0};
    endfunction

    task automatic madv(input int i);
        if (act[i]) begin
            if (rr[i] != 0 && nn[i] == end_n(i))
                act[i] = 1'b0;
            else if (stop)
                act[i] = 1'b0;
            else
                nn[i]++;
        end else if (start && !stop && mode != 2'd0) begin
            act[i] = 1'b1;
            nn[i]  = 0;
            mm[i]  = int'(mode);
            rr[i]  = int'(rep_count);
        end
    endtask

    initial begin
        bit in_rst;
        tk[0] = 4;
        tk[1] = 1;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            nn[i]  = 0;
            mm[i]  = 0;
            rr[i]  = 0;
        end
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 2'd0;
        rep_count = 4'd0;
        #2;
        chk("rst4", o4, 8'h00);
        chk("rst1", o1, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        in_rst = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (in_rst) begin
                rst    = 1'b0;
                in_rst = 1'b0;
            end
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 79) == 0);
            mode      = 2'($urandom_range(0, 3));
            rep_count = 4'($urandom_range(0, 3));
            if (act[0] && $urandom_range(0, 199) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                chk("arst4", o4, 8'h00);
                chk("arst1", o1, 8'h00);
                act[0] = 1'b0;
                act[1] = 1'b0;
                in_rst = 1'b1;
            end else begin
                madv(0);
                madv(1);
            end
            @(posedge clk);
            #1;
            chk("seq4", o4, mexp(0));
            chk("seq1", o1, mexp(1));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
